uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART RX path. It detects a start condition on `RX_IN` and times each bit with an edge counter at `Prescale` clocks per bit. It steps through START, DATA, optional PARITY and STOP, strobing the sampler, deserializer, start/parity/stop checkers and `data_valid` at fixed edge positions. It owns the parity checker's `par_chk_en` / `par_deassert` handshake and decides, from the checker results, whether a frame is delivered.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_edge_bit_cnt.sv | 33 +++
 rtl/uart_rx_ctrl.sv | 154 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int MIN_PRESC = 8;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Edge/bit position counters for the UART receiver: edge_cnt walks 0..presc-1
// inside a bit, bit_cnt counts completed bits within the frame.
module uart_rx_edge_bit_cnt #(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               bit_end
);

  assign bit_end = en && (edge_cnt == (presc - PRESC_W'(1)));

  // Advance edge position; wrap at the end of a bit and step the bit index.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      if (bit_end) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencer: frames the incoming bit stream, strobes the sampler,
// deserializer and checkers mid-bit, and reports the frame outcome.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               data_samp_en,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               par_deassert,
  output logic               data_valid,
  output logic               frame_err,
  output logic               parity_err
);

  rx_state_t          state_q, state_d;
  logic [PRESC_W-1:0] presc_q;
  logic               perr_q;
  logic               start_frame;
  logic               perr_set;
  logic               bit_end;
  logic               at_mid;
  logic               cnt_en;
  logic               cnt_clr;

  // Prescale values below the minimum would leave no room for the mid-bit strobe.
  function automatic logic [PRESC_W-1:0] clamp_presc(input logic [PRESC_W-1:0] p);
    return (p < PRESC_W'(MIN_PRESC)) ? PRESC_W'(MIN_PRESC) : p;
  endfunction

  // Checker strobes fire two clocks past the bit centre so the sampler has settled.
  assign at_mid  = (edge_cnt == ((presc_q >> 1) + PRESC_W'(2)));
  assign cnt_en  = (state_q != ST_IDLE);
  assign cnt_clr = start_frame || (state_d == ST_IDLE);

  uart_rx_edge_bit_cnt #(.PRESC_W(PRESC_W)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .presc    (presc_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (bit_end)
  );

  // State register plus frame-scoped prescale and sticky parity error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      presc_q <= PRESC_W'(MIN_PRESC);
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_frame) begin
        presc_q <= clamp_presc(Prescale);
        perr_q  <= 1'b0;
      end else if (perr_set) begin
        perr_q  <= 1'b1;
      end
    end
  end

  // Next-state, strobe decode and frame result; reset silences everything.
  always_comb begin
    state_d      = state_q;
    start_frame  = 1'b0;
    perr_set     = 1'b0;
    data_samp_en = 1'b0;
    deser_en     = 1'b0;
    strt_chk_en  = 1'b0;
    par_chk_en   = 1'b0;
    stp_chk_en   = 1'b0;
    par_deassert = 1'b0;
    data_valid   = 1'b0;
    frame_err    = 1'b0;
    parity_err   = 1'b0;
    if (RST) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!RX_IN) begin
            state_d      = ST_START;
            start_frame  = 1'b1;
            par_deassert = 1'b1;
          end
        end
        ST_START: begin
          data_samp_en = 1'b1;
          strt_chk_en  = at_mid;
          if (bit_end) begin
            if (strt_glitch) begin
              frame_err = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              state_d   = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          data_samp_en = 1'b1;
          deser_en     = at_mid;
          if (bit_end && (bit_cnt == 4'(DATA_BITS)))
            state_d = PAR_EN ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          data_samp_en = 1'b1;
          par_chk_en   = at_mid;
          if (bit_end) begin
            perr_set = par_err;
            state_d  = ST_STOP;
          end
        end
        ST_STOP: begin
          data_samp_en = 1'b1;
          stp_chk_en   = at_mid;
          if (bit_end)
            state_d = ST_DONE;
        end
        ST_DONE: begin
          if (stp_err)
            frame_err  = 1'b1;
          else if (perr_q)
            parity_err = 1'b1;
          else
            data_valid = 1'b1;
          if (!RX_IN) begin
            state_d      = ST_START;
            start_frame  = 1'b1;
            par_deassert = 1'b1;
          end else begin
            state_d      = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed and random frames compared
// cycle by cycle against a bit-timing model derived from frame arithmetic.
module tb_uart_rx_ctrl;

  localparam int PRESC_W = 6;

  logic               CLK = 1'b0;
  logic               RST;
  logic               RX_IN;
  logic               PAR_EN;
  logic [PRESC_W-1:0] Prescale;
  logic               strt_glitch;
  logic               par_err;
  logic               stp_err;
  logic [PRESC_W-1:0] edge_cnt;
  logic [3:0]         bit_cnt;
  logic               data_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic               par_deassert, data_valid, frame_err, parity_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int        p;
    bit        pe;
    bit        gl;
    bit        serr;
    bit        perr;
    bit        b2b;
    logic [7:0] data;
  } cfg_t;

  cfg_t cfgs[$];

  logic [18:0] obs;

  uart_rx_ctrl #(.PRESC_W(PRESC_W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .Prescale     (Prescale),
    .strt_glitch  (strt_glitch),
    .par_err      (par_err),
    .stp_err      (stp_err),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .data_samp_en (data_samp_en),
    .deser_en     (deser_en),
    .strt_chk_en  (strt_chk_en),
    .par_chk_en   (par_chk_en),
    .stp_chk_en   (stp_chk_en),
    .par_deassert (par_deassert),
    .data_valid   (data_valid),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  always #5 CLK = ~CLK;

  assign obs = {data_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                par_deassert, data_valid, frame_err, parity_err, edge_cnt, bit_cnt};

  function automatic logic [18:0] pack(input bit samp, input bit des, input bit sck,
                                       input bit pck, input bit stck, input bit pdas,
                                       input bit dv, input bit fe, input bit pe,
                                       input int e_pos, input int bc);
    return {samp, des, sck, pck, stck, pdas, dv, fe, pe, 6'(e_pos), 4'(bc)};
  endfunction

  // Expected outputs at cycle t of a frame (t=0 is the cycle RX_IN is seen low).
  function automatic logic [18:0] model(input int t, input cfg_t c, input bit nxt);
    int P, mid, nbits, k, e;
    bit perr_eff;
    P        = (c.p < 8) ? 8 : c.p;
    mid      = P / 2 + 2;
    nbits    = c.gl ? 1 : 10 + int'(c.pe);
    perr_eff = c.pe && c.perr;
    if (t == 0)
      return pack(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    if (t <= nbits * P) begin
      k = (t - 1) / P;
      e = (t - 1) % P;
      return pack(1, (k >= 1) && (k <= 8) && (e == mid), (k == 0) && (e == mid),
                  c.pe && (k == 9) && (e == mid), (k >= 9) && (k == nbits - 1) && (e == mid),
                  0, 0, c.gl && (e == P - 1), 0, e, k);
    end
    return pack(0, 0, 0, 0, 0, nxt, !c.serr && !perr_eff, c.serr,
                !c.serr && perr_eff, 0, nbits);
  endfunction

  function automatic logic rx_bit(input int t, input cfg_t c);
    int P, k;
    P = (c.p < 8) ? 8 : c.p;
    if (t == 0) return 1'b0;
    if (c.gl) return (t <= 2) ? 1'b0 : 1'b1;
    k = (t - 1) / P;
    if (k == 0) return 1'b0;
    if (k <= 8) return c.data[k-1];
    if (k == 9 && c.pe) return ^c.data;
    return 1'b1;
  endfunction

  function automatic int pick_p();
    case ($urandom_range(0, 3))
      0:       return 4;
      1:       return 8;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  task automatic chk(input string tag, input int t, input logic [18:0] exp);
    #1;
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s t=%0d observed %h expected %h", tag, t, obs, exp);
      end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      RX_IN    = 1'b1;
      Prescale = 6'(pick_p());
      chk("idle", i, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  // Run one frame; stop_at >= 0 truncates the frame after that cycle.
  task automatic frame(input cfg_t c, input bit skip0, input bit nxt,
                       input int nxt_p, input int stop_at);
    int P, last;
    P    = (c.p < 8) ? 8 : c.p;
    last = c.gl ? P : (10 + int'(c.pe)) * P + 1;
    if (stop_at >= 0) last = stop_at;
    for (int t = (skip0 ? 1 : 0); t <= last; t++) begin
      @(negedge CLK);
      RX_IN = rx_bit(t, c);
      if (t == 0) begin
        Prescale = 6'(c.p);
      end else begin
        Prescale = 6'(pick_p());
        if (t == 1) begin
          PAR_EN      = c.pe;
          strt_glitch = c.gl;
          par_err     = c.perr;
          stp_err     = c.serr;
        end
      end
      if (t == last && !c.gl && stop_at < 0) begin
        RX_IN    = !nxt;
        Prescale = 6'(nxt_p);
      end
      chk(c.gl ? "glitch" : "frame", t, model(t, c, nxt));
    end
  endtask

  initial begin
    cfg_t c;
    bit   skip, nxt;
    int   np;
    int   ndir;

    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b1; stp_err = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("reset", 0, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle(2);

    cfgs.push_back('{p: 8,  pe: 0, gl: 0, serr: 0, perr: 0, b2b: 0, data: 8'hA5});
    cfgs.push_back('{p: 16, pe: 1, gl: 0, serr: 0, perr: 1, b2b: 1, data: 8'h3C});
    cfgs.push_back('{p: 16, pe: 1, gl: 0, serr: 0, perr: 0, b2b: 0, data: 8'h96});
    cfgs.push_back('{p: 8,  pe: 0, gl: 1, serr: 0, perr: 0, b2b: 0, data: 8'h00});
    cfgs.push_back('{p: 16, pe: 0, gl: 0, serr: 1, perr: 0, b2b: 1, data: 8'h5A});
    cfgs.push_back('{p: 16, pe: 0, gl: 0, serr: 0, perr: 0, b2b: 0, data: 8'hC3});
    cfgs.push_back('{p: 32, pe: 1, gl: 0, serr: 0, perr: 0, b2b: 0, data: 8'h7E});
    cfgs.push_back('{p: 4,  pe: 0, gl: 0, serr: 0, perr: 0, b2b: 0, data: 8'h81});
    ndir = cfgs.size();
    for (int i = 0; i < 12; i++) begin
      c.p    = pick_p();
      c.pe   = 1'($urandom_range(0, 1));
      c.gl   = ($urandom_range(0, 7) == 0);
      c.serr = ($urandom_range(0, 4) == 0);
      c.perr = ($urandom_range(0, 3) == 0);
      c.b2b  = !c.gl && ($urandom_range(0, 2) == 0);
      c.data = 8'($urandom);
      cfgs.push_back(c);
    end

    skip = 1'b0;
    for (int i = 0; i < cfgs.size(); i++) begin
      if (i == ndir) begin
        // Reset in the middle of DATA (bit_cnt == 4), then recover.
        c = '{p: 8, pe: 0, gl: 0, serr: 0, perr: 0, b2b: 0, data: 8'h55};
        frame(c, 1'b0, 1'b0, 8, 4 * 8 + 3);
        @(negedge CLK);
        RST = 1'b1; RX_IN = 1'b1;
        @(negedge CLK);
        RST = 1'b0; RX_IN = 1'b1;
        chk("rst_mid", 0, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        idle(1);
        frame(c, 1'b0, 1'b0, 8, -1);
        idle(2);
      end
      nxt = cfgs[i].b2b && (i + 1 < cfgs.size());
      np  = nxt ? cfgs[i+1].p : pick_p();
      frame(cfgs[i], skip, nxt, np, -1);
      if (!nxt) idle(2);
      skip = nxt;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
